// File: rtl/riscv_muldiv_unit.sv
// RV32M/RV64M multi-cycle multiply/divide unit: unsigned shift-add multiplier and
// restoring divider sharing one accumulator, with sign fix-up on the final edge.
module riscv_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1,
    parameter int DIV_STEP = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   MUL_LAST = CW'(XLEN / MUL_STEP - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN / DIV_STEP - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CW-1:0]     count_r;
    logic [2:0]        op_r;
    logic              neg_res_r;
    logic              neg_rem_r;
    logic [XLEN-1:0]   mcand_r;
    logic [2*XLEN-1:0] acc_r;

    logic              launch_s;
    logic              finish_s;
    logic              fast_s;
    logic              a_signed_s;
    logic              b_signed_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic [XLEN-1:0]   fast_res_s;
    logic [2*XLEN-1:0] acc_next_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_s;

    // Accumulator holds {partial product high, remaining multiplier bits}.
    function automatic logic [2*XLEN-1:0] mul_iter(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   mcand);
        logic [2*XLEN-1:0] p;
        logic [XLEN:0]     sum;
        p = acc;
        for (int k = 0; k < MUL_STEP; k++) begin
            sum = {1'b0, p[2*XLEN-1:XLEN]} + ({1'b0, mcand} & {(XLEN+1){p[0]}});
            p   = {sum, p[XLEN-1:1]};
        end
        return p;
    endfunction

    // Accumulator holds {partial remainder, dividend bits / quotient bits}.
    function automatic logic [2*XLEN-1:0] div_iter(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   divisor);
        logic [2*XLEN-1:0] p;
        logic [XLEN:0]     trial;
        logic [XLEN:0]     diff;
        p = acc;
        for (int k = 0; k < DIV_STEP; k++) begin
            trial = {p[2*XLEN-1:XLEN], p[XLEN-1]};
            diff  = trial - {1'b0, divisor};
            if (!diff[XLEN]) begin
                p = {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
            end else begin
                p = {trial[XLEN-1:0], p[XLEN-2:0], 1'b0};
            end
        end
        return p;
    endfunction

    // Operand sign/magnitude decode and fast-path detection for a new launch.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        fast_s     = 1'b0;
        fast_res_s = ZERO;
        if (funct3[2]) begin
            a_signed_s = ~funct3[0];
            b_signed_s = ~funct3[0];
            if (rs2 == ZERO) begin
                fast_s     = 1'b1;
                fast_res_s = funct3[1] ? rs1 : ALL_ONES;
            end else if (!funct3[0] && (rs1 == MOST_NEG) && (rs2 == ALL_ONES)) begin
                fast_s     = 1'b1;
                fast_res_s = funct3[1] ? ZERO : MOST_NEG;
            end else begin
                fast_s = 1'b0;
            end
        end else begin
            a_signed_s = (funct3 != 3'd3);
            b_signed_s = ~funct3[1];
        end
        a_neg_s = a_signed_s & rs1[XLEN-1];
        b_neg_s = b_signed_s & rs2[XLEN-1];
        a_mag_s = a_neg_s ? (ZERO - rs1) : rs1;
        b_mag_s = b_neg_s ? (ZERO - rs2) : rs2;
    end

    // Next-state logic; kill overrides start in every state.
    always_comb begin
        state_s  = state_r;
        launch_s = (state_r != CALC) && start && !kill;
        finish_s = (state_r == CALC) && !kill && (count_r == {CW{1'b0}});
        case (state_r)
            IDLE, DONE: begin
                if (launch_s) begin
                    state_s = fast_s ? DONE : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (kill) begin
                    state_s = IDLE;
                end else if (finish_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // One iteration of the active datapath plus the sign-corrected final value.
    always_comb begin
        acc_next_s = op_r[2] ? div_iter(acc_r, mcand_r) : mul_iter(acc_r, mcand_r);
        prod_fix_s = neg_res_r ? ({(2*XLEN){1'b0}} - acc_next_s) : acc_next_s;
        quot_s     = neg_res_r ? (ZERO - acc_next_s[XLEN-1:0]) : acc_next_s[XLEN-1:0];
        rem_s      = neg_rem_r ? (ZERO - acc_next_s[2*XLEN-1:XLEN])
                               : acc_next_s[2*XLEN-1:XLEN];
        case (op_r)
            3'd0:       final_s = prod_fix_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       final_s = prod_fix_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: final_s = quot_s;
            3'd6, 3'd7: final_s = rem_s;
            default:    final_s = ZERO;
        endcase
    end

    // State, operand latch, iteration and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            count_r   <= {CW{1'b0}};
            op_r      <= 3'd0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            mcand_r   <= ZERO;
            acc_r     <= {(2*XLEN){1'b0}};
            result    <= ZERO;
        end else begin
            state_r <= state_s;
            if (launch_s) begin
                op_r      <= funct3;
                neg_res_r <= a_neg_s ^ b_neg_s;
                neg_rem_r <= a_neg_s;
                mcand_r   <= funct3[2] ? b_mag_s : a_mag_s;
                acc_r     <= {ZERO, (funct3[2] ? a_mag_s : b_mag_s)};
                count_r   <= funct3[2] ? DIV_LAST : MUL_LAST;
                if (fast_s) begin
                    result <= fast_res_s;
                end
            end else if ((state_r == CALC) && !kill) begin
                acc_r   <= acc_next_s;
                count_r <= count_r - 1'b1;
                if (finish_s) begin
                    result <= final_s;
                end
            end
        end
    end

    assign busy = (state_r == CALC);
    assign done = (state_r == DONE);

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench: two instances (default steps, and MUL_STEP=4/DIV_STEP=2)
// driven identically and compared with an arithmetic reference model.
module tb_riscv_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy, done, busy2, done2;
    logic [31:0] result, result2;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_exp = 32'd0;

    riscv_muldiv_unit #(.XLEN(32), .MUL_STEP(1), .DIV_STEP(1)) u_dut (
        .clock(clock), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
    );

    riscv_muldiv_unit #(.XLEN(32), .MUL_STEP(4), .DIV_STEP(2)) u_dut2 (
        .clock(clock), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .busy(busy2), .done(done2), .result(result2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b, input int ms, input int ds);
        if (f[2] && ((b == 32'd0) ||
            (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)))) return 1;
        return f[2] ? (32 / ds + 1) : (32 / ms + 1);
    endfunction

    // Launch one op on both instances and check results, latencies and busy span.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit interfere);
        logic [31:0] exp, res1, res2;
        int lat1, lat2, busy_cnt, overlap, e1, e2;
        exp  = ref_result(f, a, b);
        e1   = exp_lat(f, a, b, 1, 1);
        e2   = exp_lat(f, a, b, 4, 2);
        lat1 = 0; lat2 = 0; busy_cnt = 0; overlap = 0;
        res1 = 32'd0; res2 = 32'd0;
        @(negedge clock);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        @(negedge clock);
        start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
        for (int c = 1; c <= 80; c++) begin
            if (c > 1) @(negedge clock);
            if (busy) busy_cnt++;
            if ((busy && done) || (busy2 && done2)) overlap++;
            if (done && lat1 == 0) begin lat1 = c; res1 = result; end
            if (done2 && lat2 == 0) begin lat2 = c; res2 = result2; end
            if (interfere && c == 5) begin
                start = 1'b1; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
            end
            if (c == 6) start = 1'b0;
            if (lat1 != 0 && lat2 != 0) break;
        end
        start = 1'b0;
        check({tag, " result"}, {32'd0, res1}, {32'd0, exp});
        check({tag, " result2"}, {32'd0, res2}, {32'd0, exp});
        check({tag, " latency"}, 64'(lat1), 64'(e1));
        check({tag, " latency2"}, 64'(lat2), 64'(e2));
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(e1 - 1));
        check({tag, " busy/done overlap"}, 64'(overlap), 64'd0);
        last_exp = exp;
    endtask

    task automatic wait_done(output int lat, output logic [31:0] res);
        lat = 0;
        res = 32'd0;
        for (int c = 1; c <= 80; c++) begin
            if (done) begin lat = c; res = result; break; end
            @(negedge clock);
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            if (done || done2) n++;
        end
    endtask

    initial begin
        int          lat, n;
        logic [31:0] res, a, b;
        logic [2:0]  f;
        reset = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) @(negedge clock);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset result", {32'd0, result}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle busy", {62'd0, busy, busy2}, 64'd0);
        check("idle done", {62'd0, done, done2}, 64'd0);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul (start during CALC)", 1'b1);
        run_op(3'd0, 32'd0, 32'd5, "mul zero", 1'b0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh", 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu", 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div", 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem", 1'b0);
        run_op(3'd5, 32'd100, 32'd7, "divu", 1'b0);
        run_op(3'd7, 32'd100, 32'd7, "remu", 1'b0);
        run_op(3'd5, 32'd5, 32'd0, "divu by zero", 1'b0);
        run_op(3'd7, 32'd5, 32'd0, "remu by zero", 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow", 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem overflow", 1'b0);

        // kill ten cycles into a divide
        @(negedge clock);
        start = 1'b1; funct3 = 3'd4; rs1 = 32'h1234_5678; rs2 = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        kill = 1'b1;
        @(negedge clock);
        kill = 1'b0;
        check("kill busy drop", {62'd0, busy, busy2}, 64'd0);
        count_dones(40, n);
        check("kill no done", 64'(n), 64'd0);
        check("kill result kept", {32'd0, result}, {32'd0, last_exp});
        check("kill result2 kept", {32'd0, result2}, {32'd0, last_exp});

        // kill together with start launches nothing
        start = 1'b1; kill = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
        @(negedge clock);
        start = 1'b0; kill = 1'b0;
        check("kill+start busy", {62'd0, busy, busy2}, 64'd0);
        count_dones(40, n);
        check("kill+start no done", 64'(n), 64'd0);
        check("kill+start result kept", {32'd0, result}, {32'd0, last_exp});

        // back-to-back multiplies with start held in the DONE cycle
        a = $urandom; b = $urandom;
        start = 1'b1; funct3 = 3'd1; rs1 = a; rs2 = b;
        @(negedge clock);
        start = 1'b0;
        wait_done(lat, res);
        check("b2b first latency", 64'(lat), 64'd33);
        check("b2b first result", {32'd0, res}, {32'd0, ref_result(3'd1, a, b)});
        a = $urandom; b = $urandom;
        start = 1'b1; funct3 = 3'd0; rs1 = a; rs2 = b;
        @(negedge clock);
        start = 1'b0;
        wait_done(lat, res);
        check("b2b second spacing", 64'(lat), 64'd33);
        check("b2b second result", {32'd0, res}, {32'd0, ref_result(3'd0, a, b)});
        last_exp = ref_result(3'd0, a, b);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 15);
                default: ;
            endcase
            run_op(f, a, b, "random", (f < 3'd4) && (i % 4 == 0));
        end

        // asynchronous reset in the middle of a multiply
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul before reset", 1'b0);
        start = 1'b1; funct3 = 3'd3; rs1 = $urandom; rs2 = $urandom;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("pre-reset busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("async reset busy", {62'd0, busy, busy2}, 64'd0);
        check("async reset result", {32'd0, result}, 64'd0);
        check("async reset result2", {32'd0, result2}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        count_dones(40, n);
        check("reset no done", 64'(n), 64'd0);
        run_op(3'd5, 32'd1000, 32'd9, "divu after reset", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
Parametrised multi-cycle RV32M/RV64M multiply/divide unit. It replaces the fixed single-mode multiplier in the execute stage of the RISC-V core. The unit accepts one operation per start pulse and iterates an unsigned shift-add multiplier or a restoring divider at a configurable number of bits per cycle. Signs are applied on completion, and results are reported with a one-cycle done pulse. The execute stage holds the pipeline while busy is high and supports abort on pipeline flush.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
MUL_STEP, 1, multiplier bits retired per cycle; legal values 1, 2, 4; XLEN % MUL_STEP == 0.
DIV_STEP, 1, quotient bits retired per cycle; legal values 1, 2, 4; XLEN % DIV_STEP == 0.

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  reset, asynchronous, active-high
start  in  1  launch operation; sampled only when state is IDLE or DONE
kill   in  1  abort current operation (pipeline flush)
funct3  in  3  RV32M funct3: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu
rs1  in  XLEN  operand 1 (multiplicand / dividend)
rs2  in  XLEN  operand 2 (multiplier / divisor)
busy  out  1  high while state is CALC
done  out  1  one-cycle pulse; result valid in that cycle
result  out  XLEN  result register; holds its value until the next done

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, result=0, iteration counter=0, internal accumulators=0.
- States and transitions:
  - IDLE: on start, go to CALC, or to DONE on the fast path.
  - CALC: counter runs N-1 down to 0, then go to DONE.
  - DONE: done=1 for exactly one cycle. With start, go to CALC/DONE as from IDLE; otherwise go to IDLE.
- Iteration count N: XLEN/MUL_STEP for funct3 0-3; XLEN/DIV_STEP for funct3 4-7.
- Latency: done asserts L cycles after the edge that samples start.
  - Iterative ops: L = N+1. Defaults: mul 33, div 33; DIV_STEP=2 gives div latency 17.
  - Fast path: L = 1.
- Operands, funct3 and sign flags are latched on start. rs1/rs2/funct3 may change freely afterwards.
- Sign handling:
  - Signed operands are converted to magnitude before iterating; iteration is unsigned only.
  - Multiply: mul/mulh treat both operands as signed; mulhsu treats rs1 signed, rs2 unsigned; mulhu treats both unsigned.
  - Multiply result: the product is negated when the operand signs differ. mul returns low XLEN bits; the mulh variants return high XLEN bits of the 2*XLEN product.
  - div: quotient is negated when signs differ.
  - rem: remainder takes the sign of the dividend (truncating division).
- Sign correction is applied on the final CALC edge when result is written; there is no extra cycle.
- Fast path (state goes directly to DONE, L=1):
  - Divide by zero: div/divu return all ones; rem/remu return rs1.
  - Signed overflow (rs1 = most-negative, rs2 = all ones): div returns most-negative; rem returns 0.
- Fast path does not apply to multiply, including operands of zero.
- start while busy=1 is ignored; no queueing.
- kill:
  - In CALC or DONE, state goes to IDLE on the next edge and done stays 0; result keeps its previous value.
  - kill together with start: kill wins and no operation is launched.
  - kill in IDLE has no effect.
- Asynchronous reset mid-operation returns to IDLE immediately and clears result; no done pulse is produced.
- done and busy are never high in the same cycle.
- Back-to-back operation: start sampled in the DONE cycle launches the next op, giving one op per N+1 cycles.

Test Plan:
- XLEN=32, MUL_STEP=1, mul rs1=7, rs2=0xFFFFFFFD -> done exactly 33 cycles after start, result=0xFFFFFFEB; busy high for 32 cycles.
- mulh 0x80000000 x 0x80000000 -> 0x40000000. mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- div 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF. divu 100/7 -> 14; remu -> 2. With DIV_STEP=2, latency is 17.
- divu 5/0 -> 0xFFFFFFFF and remu 5/0 -> 5, each with done 1 cycle after start. div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem -> 0; latency 1.
- Abort cases:
  - kill raised 10 cycles into a div: busy drops next cycle, no done, and result keeps its prior value.
  - kill+start in the same cycle: no launch.
  - start during CALC: ignored, and the first op's result is unaffected.
- Asserting reset mid-CALC clears result/busy asynchronously. Back-to-back mul ops with start held in the DONE cycle: both done pulses arrive 33 cycles apart with correct results.
